// File: rtl/lfsr_button_emulator.sv
// lfsr_button_emulator
// Drives NUM_BUTTONS bouncing button lines for debouncer stimulus. Press and
// release instants come from a 16-bit Galois LFSR. A force port requests
// directed presses and releases. Only one button is active at a time.
module lfsr_button_emulator #(
   parameter int          NUM_BUTTONS = 2,
   parameter int          IDX_W       = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1,
   parameter int          PERIOD_BITS = 8,
   parameter int          BOUNCE_MAX  = 2,
   parameter int          BOUNCE_LEN  = 3,
   parameter int          HOLD_CYCLES = 100,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   force_valid,
   input  logic [IDX_W-1:0]       force_idx,
   output logic [NUM_BUTTONS-1:0] btn,
   output logic [IDX_W-1:0]       active_idx,
   output logic                   busy,
   output logic                   press_pulse,
   output logic                   release_pulse
);

   // One counter covers both the hold time and the position inside a bounce
   // half-period. A second counter counts completed half-periods.
   localparam int CNT_MAX = (HOLD_CYCLES > BOUNCE_LEN) ? HOLD_CYCLES : BOUNCE_LEN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int HALVES  = 2 * BOUNCE_MAX;
   localparam int HALF_W  = (HALVES > 1) ? $clog2(HALVES) : 1;

   localparam logic [CNT_W-1:0]  BL_LAST   = CNT_W'(BOUNCE_LEN - 1);
   localparam logic [CNT_W-1:0]  HOLD_DONE = CNT_W'(HOLD_CYCLES);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'((HALVES > 0) ? HALVES - 1 : 0);
   localparam logic [15:0]       SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0]       TAPS      = 16'hB400;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_BOUNCE,
      HELD,
      RELEASE_BOUNCE
   } state_e;

   state_e                   state_q, state_d;
   logic [15:0]              lfsr_q, lfsr_d, lfsr_shift;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [HALF_W-1:0]        half_q, half_d;
   logic [NUM_BUTTONS-1:0]   btn_d;
   logic [IDX_W-1:0]         idx_d, rand_idx;
   logic                     busy_d, press_d, release_d;
   logic                     rand_fire, force_ok;

   // Single set bit at position i.
   function automatic logic [NUM_BUTTONS-1:0] onehot(input logic [IDX_W-1:0] i);
      logic [NUM_BUTTONS-1:0] v;
      v    = '0;
      v[0] = 1'b1;
      return v << i;
   endfunction

   assign lfsr_shift = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
   assign rand_fire  = (lfsr_q[PERIOD_BITS-1:0] == '0);
   assign force_ok   = force_valid && (32'(force_idx) < NUM_BUTTONS);
   assign rand_idx   = IDX_W'(32'(lfsr_q[15:8]) % NUM_BUTTONS);

   // Next-state and next-output decode; everything freezes while en is low
   // except the pulses, which always fall after one cycle.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      cnt_d     = cnt_q;
      half_d    = half_q;
      btn_d     = btn;
      idx_d     = active_idx;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (en) begin
         lfsr_d = lfsr_shift;
         unique case (state_q)
            IDLE: begin
               btn_d = '0;
               if (force_ok || rand_fire) begin
                  idx_d  = force_ok ? force_idx : rand_idx;
                  btn_d  = onehot(idx_d);
                  cnt_d  = '0;
                  half_d = '0;
                  if (BOUNCE_MAX > 0) begin
                     state_d = PRESS_BOUNCE;
                  end else begin
                     state_d = HELD;
                     press_d = 1'b1;
                  end
               end
            end
            PRESS_BOUNCE, RELEASE_BOUNCE: begin
               if (cnt_q == BL_LAST) begin
                  cnt_d = '0;
                  btn_d = btn ^ onehot(active_idx);
                  if (half_q == HALF_LAST) begin
                     half_d = '0;
                     if (state_q == PRESS_BOUNCE) begin
                        state_d = HELD;
                        btn_d   = onehot(active_idx);
                        press_d = 1'b1;
                     end else begin
                        state_d   = IDLE;
                        btn_d     = '0;
                        release_d = 1'b1;
                     end
                  end else begin
                     half_d = half_q + HALF_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            HELD: begin
               btn_d = onehot(active_idx);
               if (cnt_q != HOLD_DONE) begin
                  // Forces before the hold time is met fall through here and are dropped.
                  cnt_d = cnt_q + CNT_W'(1);
               end else if (force_valid || rand_fire) begin
                  cnt_d = '0;
                  btn_d = '0;
                  if (BOUNCE_MAX > 0) begin
                     state_d = RELEASE_BOUNCE;
                  end else begin
                     state_d   = IDLE;
                     release_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   // State, LFSR, counters and registered outputs; reset aborts immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q       <= IDLE;
         lfsr_q        <= SEED_EFF;
         cnt_q         <= '0;
         half_q        <= '0;
         btn           <= '0;
         active_idx    <= '0;
         busy          <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state_q       <= state_d;
         lfsr_q        <= lfsr_d;
         cnt_q         <= cnt_d;
         half_q        <= half_d;
         btn           <= btn_d;
         active_idx    <= idx_d;
         busy          <= busy_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
      end
   end

endmodule
